// File: rtl/tmr_scrub_arb.sv
// ---------------------------------------------------------------------------
// tmr_scrub_arb
//
// Front-end arbiter for the triplicated, majority-voted memory. It owns the
// memory's single we/re/addr/wdata port and merges two traffic sources:
//   - host reads/writes (valid/ready handshake, 1-cycle registered issue)
//   - a background scrub walker that reads successive addresses so that
//     the memory's scrub-on-read logic repairs latent upsets.
// After every scrub read the arbiter spends one HOLD cycle refusing the
// host. That keeps the following cycle free of host writes, which is the
// cycle in which the memory performs its repair write-back.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_enable                scrub walker enable
//   i_cfg_interval          idle cycles between scrub reads
//   i_host_valid/o_host_ready, i_host_we, i_host_addr, i_host_wdata
//                           host request channel
//   o_host_rvalid           memory rdata carries the host read result
//   o_mem_we/re/addr/wdata  registered memory port
//   o_scrub_addr            next address the walker will read
//   o_sweep_done            1-cycle pulse when the walker wraps to 0
//   o_sweep_cnt             completed sweeps, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module tmr_scrub_arb #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int INT_W      = 16,
    parameter int STARVE_MAX = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [INT_W-1:0]  i_cfg_interval,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_rvalid,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [ADDR_W-1:0] o_scrub_addr,
    output logic              o_sweep_done,
    output logic [15:0]       o_sweep_cnt
);

    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PEND,
        HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [INT_W-1:0]  r_intCnt;
    logic [INT_W:0]    w_intNext;
    logic [SW-1:0]     r_starveCnt;
    logic              w_starved;
    logic              w_hostGrant;
    logic              w_scrubGrant;
    logic              r_memWe;
    logic              r_memRe;
    logic              r_hostRd;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [1:0]        r_rvPipe;
    logic [ADDR_W-1:0] r_scrubAddr;
    logic              r_sweepDone;
    logic [15:0]       r_sweepCnt;

    // State register for the scrub walker FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and grant decode. The host is refused only when a pending
    // scrub has been starved for too long and during HOLD. The interval test
    // uses the incremented count, so an interval of 0 still spends one cycle
    // in WAIT, and an interval of N spends N cycles there.
    always_comb begin
        w_next       = r_state;
        o_host_ready = 1'b0;
        w_scrubGrant = 1'b0;
        w_intNext    = {1'b0, r_intCnt} + {{INT_W{1'b0}}, 1'b1};
        w_starved    = (r_starveCnt >= STARVE_LIM);
        case (r_state)
            IDLE: begin
                o_host_ready = 1'b1;
                if (i_enable) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                o_host_ready = 1'b1;
                if (!i_enable) begin
                    w_next = IDLE;
                end else if (w_intNext >= {1'b0, i_cfg_interval}) begin
                    w_next = PEND;
                end
            end
            PEND: begin
                o_host_ready = !w_starved;
                if (!i_enable) begin
                    w_next = IDLE;
                end else if (!i_host_valid || w_starved) begin
                    w_scrubGrant = 1'b1;
                    w_next       = HOLD;
                end
            end
            HOLD: begin
                w_next = i_enable ? WAIT : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_hostGrant = i_host_valid & o_host_ready;

    // Interval and starvation counters, plus the walker address and sweep
    // statistics. The walker only advances when a HOLD cycle completes, so
    // toggling enable never loses or skips an address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_intCnt    <= '0;
            r_starveCnt <= '0;
            r_scrubAddr <= '0;
            r_sweepDone <= 1'b0;
            r_sweepCnt  <= '0;
        end else begin
            r_sweepDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_intCnt    <= '0;
                    r_starveCnt <= '0;
                end
                WAIT: begin
                    r_intCnt <= w_intNext[INT_W-1:0];
                end
                PEND: begin
                    r_intCnt <= '0;
                    if (!w_starved) begin
                        r_starveCnt <= r_starveCnt + SW'(1);
                    end
                end
                HOLD: begin
                    r_intCnt    <= '0;
                    r_starveCnt <= '0;
                    r_scrubAddr <= r_scrubAddr + ADDR_W'(1);
                    if (&r_scrubAddr) begin
                        r_sweepDone <= 1'b1;
                        if (r_sweepCnt != 16'hFFFF) begin
                            r_sweepCnt <= r_sweepCnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_intCnt <= '0;
                end
            endcase
        end
    end

    // Registered memory port. Host and scrub grants never coincide. On a
    // scrub grant the write data is left alone; it is irrelevant for a read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_memWe    <= 1'b0;
            r_memRe    <= 1'b0;
            r_hostRd   <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            r_memWe  <= w_hostGrant & i_host_we;
            r_memRe  <= (w_hostGrant & ~i_host_we) | w_scrubGrant;
            r_hostRd <= w_hostGrant & ~i_host_we;
            if (w_hostGrant) begin
                r_memAddr  <= i_host_addr;
                r_memWdata <= i_host_wdata;
            end else if (w_scrubGrant) begin
                r_memAddr <= r_scrubAddr;
            end
        end
    end

    // Two-stage delay tracking the memory's read path, so host_rvalid lines
    // up with rdata. Scrub reads never enter this pipe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvPipe <= '0;
        end else begin
            r_rvPipe <= {r_rvPipe[0], r_memRe & r_hostRd};
        end
    end

    assign o_host_rvalid = r_rvPipe[1];
    assign o_mem_we      = r_memWe;
    assign o_mem_re      = r_memRe;
    assign o_mem_addr    = r_memAddr;
    assign o_mem_wdata   = r_memWdata;
    assign o_scrub_addr  = r_scrubAddr;
    assign o_sweep_done  = r_sweepDone;
    assign o_sweep_cnt   = r_sweepCnt;

endmodule
